// File: rtl/pomdp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pomdp_pkg
//  Description : Shared types and helpers for the POMDP episode sequencer:
//                FSM state encoding, LFSR constants and a saturating adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package pomdp_pkg;

  // Episode sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECIDE  = 3'd1,
    STATE   = 3'd2,
    OBSERVE = 3'd3,
    BELIEF  = 3'd4,
    REWARD  = 3'd5,
    FIN     = 3'd6,
    ERR     = 3'd7
  } ep_state_t;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  // Reset value and replacement for an all-zero seed
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Signed add clamped to the range of a w-bit signed number (w <= 63).
  // Operands must already be sign-extended to 64 bits.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        w);
    sat_res_t           r;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    logic signed [63:0] s;
    mx    = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn    = -mx - 64'sd1;
    s     = a + b;
    r.sat = 1'b0;
    r.val = s;
    if (s > mx) begin
      r.val = mx;
      r.sat = 1'b1;
    end else if (s < mn) begin
      r.val = mn;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pomdp_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : pomdp_lfsr16
//  Description : 16-bit Fibonacci LFSR with synchronous load and step enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module pomdp_lfsr16
  import pomdp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  // Load has priority over stepping; shift left, feedback enters at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= DEFAULT_SEED;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule
`default_nettype wire

// File: rtl/pomdp_episode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pomdp_episode_ctrl
//  Description : Episode sequencer driving decision, state, observation and
//                belief engines one handshaked step at a time, with watchdog,
//                hidden-state ownership and saturating reward accumulation.
//  Revision    : 1.0 - initial release
// ============================================================================
module pomdp_episode_ctrl
  import pomdp_pkg::*;
#(
  parameter  int N_STATES  = 2,
  parameter  int N_ACTIONS = 4,
  parameter  int N_OBS     = 2,
  parameter  int RW        = 16,
  parameter  int ACC_W     = 32,
  parameter  int STEP_W    = 16,
  parameter  int TIMEOUT   = 255,
  localparam int SW        = (N_STATES  > 1) ? $clog2(N_STATES)  : 1,
  localparam int AW        = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1,
  localparam int OW        = (N_OBS     > 1) ? $clog2(N_OBS)     : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [STEP_W-1:0]                            n_steps,
  input  logic [SW-1:0]                                init_state,
  input  logic [15:0]                                  seed,
  input  logic [N_STATES-1:0][N_ACTIONS-1:0][RW-1:0]   reward_tab,
  output logic                                         dec_en,
  input  logic                                         dec_done,
  input  logic [AW-1:0]                                dec_action,
  output logic                                         st_en,
  input  logic                                         st_done,
  input  logic [SW-1:0]                                st_new_state,
  output logic                                         obs_en,
  input  logic                                         obs_done,
  input  logic [OW-1:0]                                obs_value,
  output logic                                         bel_en,
  input  logic                                         bel_done,
  output logic [15:0]                                  rnd,
  output logic [SW-1:0]                                cur_state,
  output logic [AW-1:0]                                action,
  output logic [OW-1:0]                                observation,
  output logic                                         busy,
  output logic                                         ep_done,
  output logic                                         err,
  output logic                                         sat,
  output logic [STEP_W-1:0]                            step_cnt,
  output logic signed [ACC_W-1:0]                      total_reward
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  ep_state_t          state;
  ep_state_t          nstate;
  logic               first;
  logic [WDW-1:0]     wd;
  logic               wd_hit;
  logic [SW-1:0]      nxt;
  logic [STEP_W-1:0]  n_steps_q;
  logic               act_bad;
  logic               st_bad;
  logic               lfsr_load;
  logic               lfsr_step;
  logic [15:0]        seed_eff;
  logic [RW-1:0]      rew;
  logic signed [63:0] rew_ext;
  logic signed [63:0] acc_ext;
  sat_res_t           sr;
  logic               unused_hi;

  // Range checks only exist where the index width can exceed the count
  generate
    if ((1 << AW) > N_ACTIONS) begin : g_act_chk
      assign act_bad = (dec_action >= AW'(N_ACTIONS));
    end else begin : g_act_full
      assign act_bad = 1'b0;
    end
    if ((1 << SW) > N_STATES) begin : g_st_chk
      assign st_bad = (st_new_state >= SW'(N_STATES));
    end else begin : g_st_full
      assign st_bad = 1'b0;
    end
  endgenerate

  assign busy      = (state != IDLE);
  assign wd_hit    = (wd == WDW'(TIMEOUT - 1));
  assign lfsr_load = (state == IDLE) && start;
  assign seed_eff  = (seed == 16'h0000) ? DEFAULT_SEED : seed;
  // Advance exactly on entry so rnd is stable for the whole wait state
  assign lfsr_step = (nstate != state) && ((nstate == STATE) || (nstate == OBSERVE));

  pomdp_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed_eff),
    .step  (lfsr_step),
    .q     (rnd)
  );

  // Reward uses the pre-transition state and the captured action
  assign rew       = reward_tab[cur_state][action];
  assign rew_ext   = {{(64 - RW){rew[RW-1]}}, rew};
  assign acc_ext   = {{(64 - ACC_W){total_reward[ACC_W-1]}}, total_reward};
  assign sr        = sat_add(acc_ext, rew_ext, ACC_W);
  // After clamping the upper bits are only sign copies
  assign unused_hi = ^sr.val[63:ACC_W];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state and engine enables; done is honoured only after the entry cycle
  always_comb begin
    nstate = state;
    dec_en = 1'b0;
    st_en  = 1'b0;
    obs_en = 1'b0;
    bel_en = 1'b0;
    case (state)
      IDLE:    if (start) nstate = (n_steps == '0) ? FIN : DECIDE;
      DECIDE: begin
        dec_en = first;
        if (!first && dec_done) nstate = act_bad ? ERR : STATE;
        else if (wd_hit)        nstate = ERR;
      end
      STATE: begin
        st_en = first;
        if (!first && st_done) nstate = st_bad ? ERR : OBSERVE;
        else if (wd_hit)       nstate = ERR;
      end
      OBSERVE: begin
        obs_en = first;
        if (!first && obs_done) nstate = BELIEF;
        else if (wd_hit)        nstate = ERR;
      end
      BELIEF: begin
        bel_en = first;
        if (!first && bel_done) nstate = REWARD;
        else if (wd_hit)        nstate = ERR;
      end
      REWARD:  nstate = ((step_cnt + STEP_W'(1)) == n_steps_q) ? FIN : DECIDE;
      FIN:     nstate = IDLE;
      ERR:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Datapath: entry flag, watchdog, captures, accumulator and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first        <= 1'b0;
      wd           <= '0;
      nxt          <= '0;
      n_steps_q    <= '0;
      cur_state    <= '0;
      action       <= '0;
      observation  <= '0;
      step_cnt     <= '0;
      total_reward <= '0;
      sat          <= 1'b0;
      err          <= 1'b0;
      ep_done      <= 1'b0;
    end else begin
      first   <= (nstate != state);
      ep_done <= (state == FIN);
      if (nstate != state) begin
        wd <= '0;
      end else if (busy) begin
        wd <= wd + WDW'(1);
      end
      case (state)
        IDLE: if (start) begin
          n_steps_q    <= n_steps;
          cur_state    <= init_state;
          step_cnt     <= '0;
          total_reward <= '0;
          sat          <= 1'b0;
          err          <= 1'b0;
        end
        DECIDE:  if (!first && dec_done && !act_bad) action <= dec_action;
        STATE:   if (!first && st_done && !st_bad)   nxt <= st_new_state;
        OBSERVE: if (!first && obs_done)             observation <= obs_value;
        REWARD: begin
          total_reward <= sr.val[ACC_W-1:0];
          if (sr.sat) sat <= 1'b1;
          cur_state    <= nxt;
          step_cnt     <= step_cnt + STEP_W'(1);
        end
        default: ;
      endcase
      if ((nstate == ERR) && (state != ERR)) err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pomdp_episode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pomdp_episode_ctrl
//  Description : Scoreboard bench for pomdp_episode_ctrl with scripted
//                single-cycle engine models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pomdp_episode_ctrl;

  localparam int ACC_W = 20;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          start;
  logic [15:0]                   n_steps;
  logic                          init_state;
  logic [15:0]                   seed;
  logic [1:0][3:0][15:0]         reward_tab;
  logic                          dec_en, dec_done;
  logic [1:0]                    dec_action;
  logic                          st_en, st_done, st_new_state;
  logic                          obs_en, obs_done, obs_value;
  logic                          bel_en, bel_done;
  logic [15:0]                   rnd;
  logic                          cur_state;
  logic [1:0]                    action;
  logic                          observation;
  logic                          busy, ep_done, err, sat;
  logic [15:0]                   step_cnt;
  logic signed [ACC_W-1:0]       total_reward;

  pomdp_episode_ctrl #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_steps(n_steps),
    .init_state(init_state), .seed(seed), .reward_tab(reward_tab),
    .dec_en(dec_en), .dec_done(dec_done), .dec_action(dec_action),
    .st_en(st_en), .st_done(st_done), .st_new_state(st_new_state),
    .obs_en(obs_en), .obs_done(obs_done), .obs_value(obs_value),
    .bel_en(bel_en), .bel_done(bel_done), .rnd(rnd),
    .cur_state(cur_state), .action(action), .observation(observation),
    .busy(busy), .ep_done(ep_done), .err(err), .sat(sat),
    .step_cnt(step_cnt), .total_reward(total_reward)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: ep_done with final values; kind 1: err rising edge
  typedef struct {
    int                      kind;
    int                      cyc;
    logic signed [ACC_W-1:0] total;
    logic [15:0]             steps;
    logic                    st;
    logic                    sat;
  } exp_t;

  exp_t sbq[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   en_cnt    = 0;

  logic [1:0] act_scr [0:63];
  logic       st_scr  [0:63];
  logic       obs_scr [0:63];
  int         ia = 0, is = 0, io = 0;
  logic       hold_bel = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int kind, input int c, input int total,
                              input int steps, input logic st, input logic s);
    exp_t e;
    e.kind  = kind;
    e.cyc   = c;
    e.total = ACC_W'(total);
    e.steps = 16'(steps);
    e.st    = st;
    e.sat   = s;
    return e;
  endfunction

  // Engine models: done one cycle after en, output taken from the scripts
  initial begin
    logic p_dec = 1'b0, p_st = 1'b0, p_obs = 1'b0, p_bel = 1'b0;
    dec_done = 1'b0; st_done = 1'b0; obs_done = 1'b0; bel_done = 1'b0;
    dec_action = '0; st_new_state = 1'b0; obs_value = 1'b0;
    forever begin
      @(posedge clk); #1;
      dec_done = p_dec;
      st_done  = p_st;
      obs_done = p_obs;
      bel_done = p_bel && !hold_bel;
      if (p_dec && ia < 64) begin dec_action   = act_scr[ia]; ia++; end
      if (p_st  && is < 64) begin st_new_state = st_scr[is];  is++; end
      if (p_obs && io < 64) begin obs_value    = obs_scr[io]; io++; end
      p_dec = dec_en;
      p_st  = st_en;
      p_obs = obs_en;
      p_bel = bel_en;
    end
  end

  // Monitor: pops an expectation on every ep_done or err rising edge
  initial begin
    logic prev_err = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      en_cnt += int'(dec_en) + int'(st_en) + int'(obs_en) + int'(bel_en);
      if (ep_done || (err && !prev_err)) begin
        if (sbq.size() == 0) begin
          total_cnt++;
          bad_cnt++;
          $display("FAIL unexpected_event: ep_done=%0b err=%0b at cycle %0d", ep_done, err, cyc);
        end else begin
          e = sbq.pop_front();
          check("event_kind", ep_done ? 0 : 1, e.kind);
          check("event_cycle", cyc, e.cyc);
          if (e.kind == 0) begin
            check("total_reward", total_reward, e.total);
            check("step_cnt", step_cnt, e.steps);
            check("cur_state", cur_state, e.st);
            check("sat", sat, e.sat);
            check("err_at_done", err, 0);
          end
        end
      end
      prev_err = err;
    end
  end

  task automatic do_start(input logic [15:0] n, input logic s0, input logic [15:0] sd);
    n_steps    = n;
    init_state = s0;
    seed       = sd;
    ia = 0; is = 0; io = 0;
    start      = 1'b1;
    @(posedge clk); #2;
    start      = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int k = 0;
    while (sbq.size() != 0 && k < bound) begin
      @(posedge clk); #2;
      k++;
    end
    total_cnt++;
    if (sbq.size() != 0) begin
      bad_cnt++;
      $display("FAIL %s: expected event missing after %0d cycles (got %0d pending, required 0)",
               name, bound, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ep_done"}, ep_done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_en"}, {dec_en, st_en, obs_en, bel_en}, 0);
    check({tag, "_cur_state"}, cur_state, 0);
    check({tag, "_action"}, action, 0);
    check({tag, "_observation"}, observation, 0);
    check({tag, "_step_cnt"}, step_cnt, 0);
    check({tag, "_total_reward"}, total_reward, 0);
    check({tag, "_rnd"}, rnd, 16'hACE1);
  endtask

  task automatic main_table();
    reward_tab       = '0;
    reward_tab[0][1] = 16'd5;
    reward_tab[1][2] = 16'hFFFE;
    reward_tab[0][3] = 16'd7;
    act_scr[0] = 2'd1; act_scr[1] = 2'd2; act_scr[2] = 2'd3;
    st_scr[0]  = 1'b1; st_scr[1]  = 1'b0; st_scr[2]  = 1'b1;
    obs_scr[0] = 1'b1; obs_scr[1] = 1'b0; obs_scr[2] = 1'b1;
  endtask

  initial begin
    int c0;
    int k;
    int en0;
    rst_n = 1'b0; start = 1'b0; n_steps = '0; init_state = 1'b0; seed = '0;
    reward_tab = '0;
    for (int i = 0; i < 64; i++) begin
      act_scr[i] = 2'd0; st_scr[i] = 1'b0; obs_scr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Three-step episode with single-cycle engines
    main_table();
    c0 = cyc;
    sbq.push_back(mk(0, c0 + 29, 10, 3, 1'b1, 1'b0));
    do_start(16'd3, 1'b0, 16'h1234);
    drain("main_episode", 60);
    check("main_action", action, 3);
    check("main_observation", observation, 1);
    @(posedge clk); #2;

    // Zero-length episode: ep_done two cycles after start, no engine activity
    en0 = en_cnt;
    c0  = cyc;
    sbq.push_back(mk(0, c0 + 2, 0, 0, 1'b1, 1'b0));
    do_start(16'd0, 1'b1, 16'h0001);
    drain("zero_steps", 10);
    check("zero_steps_en_pulses", en_cnt - en0, 0);
    @(posedge clk); #2;

    // Saturation: 40 x 32767 clamps at the 20-bit signed maximum
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        reward_tab[s][a] = 16'h7FFF;
    for (int i = 0; i < 64; i++) begin
      act_scr[i] = 2'd0; st_scr[i] = 1'b0; obs_scr[i] = 1'b0;
    end
    c0 = cyc;
    sbq.push_back(mk(0, c0 + 362, 524287, 40, 1'b0, 1'b1));
    do_start(16'd40, 1'b0, 16'h5555);
    drain("saturation", 400);
    @(posedge clk); #2;

    // Watchdog: belief engine never answers
    main_table();
    hold_bel = 1'b1;
    c0 = cyc;
    sbq.push_back(mk(1, c0 + 7 + 255, 0, 0, 1'b0, 1'b0));
    do_start(16'd1, 1'b0, 16'h0BAD);
    drain("timeout_err", 300);
    @(posedge clk); #2;
    check("timeout_busy_drop", busy, 0);
    check("timeout_err_held", err, 1);
    hold_bel = 1'b0;
    c0 = cyc;
    sbq.push_back(mk(0, c0 + 2, 0, 0, 1'b0, 1'b0));
    do_start(16'd0, 1'b0, 16'h0001);
    check("err_cleared_on_start", err, 0);
    drain("after_timeout", 10);
    @(posedge clk); #2;

    // Zero seed behaves as 16'hACE1; a start while busy is ignored
    act_scr[0] = 2'd1; st_scr[0] = 1'b1; obs_scr[0] = 1'b0;
    c0 = cyc;
    sbq.push_back(mk(0, c0 + 11, 5, 1, 1'b1, 1'b0));
    do_start(16'd1, 1'b0, 16'h0000);
    k = 0;
    while (!st_en && k < 20) begin @(posedge clk); #2; k++; end
    check("rnd_in_state", rnd, 16'h59C3);
    n_steps = 16'd5;
    start   = 1'b1;
    @(posedge clk); #2;
    start   = 1'b0;
    k = 0;
    while (!obs_en && k < 20) begin @(posedge clk); #2; k++; end
    check("rnd_in_observe", rnd, 16'hB387);
    drain("seed_zero", 20);
    repeat (12) @(posedge clk);
    #2;
    check("busy_after_ignored_start", busy, 0);

    // Asynchronous reset during OBSERVE, then a clean episode
    main_table();
    do_start(16'd2, 1'b0, 16'h4321);
    k = 0;
    while (!obs_en && k < 20) begin @(posedge clk); #2; k++; end
    check("reached_observe", obs_en, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    c0 = cyc;
    sbq.push_back(mk(0, c0 + 29, 10, 3, 1'b1, 1'b0));
    do_start(16'd3, 1'b0, 16'h1234);
    drain("post_reset_episode", 60);
    repeat (5) @(posedge clk);
    #2;
    check("scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pomdp_episode_ctrl.md
# pomdp_episode_ctrl

Parametrised episode sequencer for the POMDP simulator. Drives the decision, state-transition, observation and belief-update engines through one handshaked step at a time, for a programmable number of steps. Owns the true hidden state, the random source and the saturating reward accumulator. Replaces the fixed 2-state, free-running top-level wiring with a controlled, observable, timeout-protected loop.

## Interface
- `N_STATES`, default 2: hidden states; `SW = $clog2(N_STATES)`, min 1.
- `N_ACTIONS`, default 4: actions; `AW = $clog2(N_ACTIONS)`.
- `N_OBS`, default 2: observations; `OW = $clog2(N_OBS)`, min 1.
- `RW`, default 16: signed reward entry width.
- `ACC_W`, default 32: signed accumulator width, must be greater than `RW`.
- `STEP_W`, default 16: step counter width.
- `TIMEOUT`, default 255: maximum cycles to wait for any engine `done`.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to begin an episode.
- `n_steps` in STEP_W: episode length, sampled on accepted `start`.
- `init_state` in SW: initial hidden state, sampled on `start`.
- `seed` in 16: LFSR seed, sampled on `start`.
- `reward_tab` in [N_STATES][N_ACTIONS][RW]: signed reward R[s][a].
- `dec_en` out 1, `dec_done` in 1, `dec_action` in AW: decision engine handshake.
- `st_en` out 1, `st_done` in 1, `st_new_state` in SW: state engine handshake.
- `obs_en` out 1, `obs_done` in 1, `obs_value` in OW: observation engine handshake.
- `bel_en` out 1, `bel_done` in 1: belief engine handshake.
- `rnd` out 16: current LFSR word, driven to the state and observation engines.
- `cur_state` out SW, `action` out AW, `observation` out OW: registered step values.
- `busy` out 1, `ep_done` out 1, `err` out 1, `sat` out 1.
- `step_cnt` out STEP_W: completed steps.
- `total_reward` out ACC_W: signed accumulated reward.

## Operation
- FSM states: `IDLE`, `DECIDE`, `STATE`, `OBSERVE`, `BELIEF`, `REWARD`, `FIN`, `ERR`.
- `IDLE` plus `start`:
  - Latch `n_steps`, `init_state` into `cur_state`, and `seed` into the LFSR. A seed of 0 is replaced by 16'hACE1.
  - Clear `step_cnt`, `total_reward`, `sat`, `err`.
  - If `n_steps == 0`, go to `FIN`; otherwise go to `DECIDE`.
- Each wait state (`DECIDE`, `STATE`, `OBSERVE`, `BELIEF`):
  - Pulse its `*_en` for one cycle on entry.
  - Wait for its `*_done`. On `done`, capture the engine output: `dec_action` into `action`, `st_new_state` into a `nxt` register, `obs_value` into `observation`.
  - Order is DECIDE → STATE → OBSERVE → BELIEF → REWARD.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances once on entry to `STATE` and once on entry to `OBSERVE`. `rnd` is stable for the whole wait state.
- `REWARD` (1 cycle):
  - `total_reward += sign_extend(R[cur_state][action])`, using the pre-transition state.
  - Saturate at the ACC_W signed max/min; on saturation set sticky `sat`.
  - `cur_state <= nxt`; `step_cnt++`.
  - Go to `FIN` if the new `step_cnt == n_steps`, else to `DECIDE`.
- `FIN`: `ep_done` is high for one cycle, then `IDLE`.
- Watchdog:
  - Per wait state, a counter is cleared on entry.
  - If it reaches `TIMEOUT` without `done`, go to `ERR` and set `err`. `err` stays high until the next accepted `start`.
  - `ERR` returns to `IDLE` the next cycle. Outputs hold their last values.
- `start` while `busy` is ignored.
- A `*_done` received in any state other than its own wait state is ignored.
- Out-of-range `st_new_state`/`dec_action` (≥ N) → `ERR`.

## Timing
- Reset values:
  - FSM `IDLE`.
  - All `*_en`, `busy`, `ep_done`, `err`, `sat` = 0.
  - `cur_state`, `action`, `observation`, `step_cnt`, `total_reward` = 0.
  - LFSR = 16'hACE1.
- `busy` = 1 in every state except `IDLE`.
- `*_en` is asserted in the first cycle of its state. `done` is accepted no earlier than the following cycle. The earliest state exit is 2 cycles after entry.
- With single-cycle engines (`done` one cycle after `en`), one step = 9 cycles and an episode = 9·n_steps + 2 cycles from `start` to `ep_done`.
- `step_cnt` wraps are impossible, since the loop ends at `n_steps`.
- Asynchronous reset mid-episode aborts immediately to reset values. No `ep_done` is issued.

## Structure
- Package `pomdp_pkg`: FSM state enum, LFSR tap constant, default seed 16'hACE1, and a saturating-add function parametrised on width.
- Sub-module `pomdp_lfsr16`: signals `clk`, `rst_n`, `load`, `seed`, `step`, `q`.
- Everything else (FSM, watchdog, accumulator) lives in one module.

## Test plan
- Single-cycle engines. Setup: `n_steps`=3, `init_state`=0, actions 1,2,3, states 1,0,1, R[0][1]=5, R[1][2]=-2, R[0][3]=7. Required: `total_reward`=10, `step_cnt`=3, `ep_done` at cycle 29, `cur_state`=1.
- `n_steps`=0: `ep_done` 2 cycles after `start`; no `*_en` pulses.
- Setup: ACC_W=20, R=16'h7FFF, 40 steps. Required: `total_reward` clamps at 524287, `sat`=1.
- `bel_done` withheld. Required: `err` = 1 exactly TIMEOUT cycles after `bel_en`, `busy` drops the next cycle, and `err` clears on the next `start`.
- `seed`=0. Required: `rnd` sequence equals that of seed 16'hACE1. A second `start` asserted mid-episode is ignored.
- `rst_n` asserted during `OBSERVE`. Required: all outputs at reset values; a subsequent `start` runs a clean episode.
